// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Lets several byte-stream sources share one UART transmitter. Grants are
// round-robin and cover whole packets: one owner keeps the TX byte interface
// from its first byte until it sends `last`, so frames from different sources
// never interleave. A per-packet byte limit forces a release so that a stuck
// source cannot hold the UART forever.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req_valid    per-requester byte valid                    [NUM_REQ]
//   req_data     per-requester byte, lane i at [i*DATA_W +: DATA_W]
//   req_last     per-requester end-of-packet marker          [NUM_REQ]
//   req_ready    per-requester accept (only the owner's lane can be 1)
//   tx_valid     byte valid towards the UART TX
//   tx_data      byte towards the UART TX
//   tx_ready     UART TX accepts the byte
//   grant_valid  a requester currently owns the UART
//   grant_id     index of the owner, 0 while nobody owns it
//   pkt_overrun  one-cycle pulse after a packet is cut at MAX_PKT bytes
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_ready,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          pkt_overrun
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pkt_overrun_q, pkt_overrun_d;

    logic [ID_W-1:0]   scan_idx_s;
    logic [ID_W-1:0]   pick_id_s;
    logic              pick_found_s;
    logic              owner_valid_s;
    logic              owner_last_s;
    logic [DATA_W-1:0] owner_data_s;
    logic              hs_s;
    logic              at_limit_s;

    // Round-robin pick: first valid requester after last_grant, with wrap.
    always_comb begin
        scan_idx_s   = '0;
        pick_id_s    = '0;
        pick_found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s   = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            pick_id_s    = (!pick_found_s && req_valid[scan_idx_s]) ? scan_idx_s : pick_id_s;
            pick_found_s = pick_found_s | req_valid[scan_idx_s];
        end
    end

    // Select the owner's lane (AND-OR mux keeps the index math constant).
    always_comb begin
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_valid_s = owner_valid_s | ((owner_q == ID_W'(i)) & req_valid[i]);
            owner_last_s  = owner_last_s  | ((owner_q == ID_W'(i)) & req_last[i]);
            owner_data_s  = owner_data_s  |
                            ({DATA_W{owner_q == ID_W'(i)}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state logic and the BUSY pass-through outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        pkt_overrun_d = 1'b0;
        req_ready     = '0;
        tx_valid      = 1'b0;
        tx_data       = '0;
        grant_valid   = 1'b0;
        grant_id      = '0;
        hs_s          = 1'b0;
        at_limit_s    = (cnt_q == 8'(MAX_PKT - 1));

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    owner_d = pick_id_s;
                    cnt_d   = 8'd0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                grant_valid = 1'b1;
                grant_id    = owner_q;
                tx_valid    = owner_valid_s;
                tx_data     = owner_data_s;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (owner_q == ID_W'(i)) & tx_ready;
                end
                hs_s = owner_valid_s & tx_ready;
                if (hs_s) begin
                    if (owner_last_s || at_limit_s) begin
                        state_d       = ST_IDLE;
                        last_grant_d  = owner_q;
                        cnt_d         = 8'd0;
                        // A limit cut on a byte that was not marked last is an overrun;
                        // the source's following byte opens a fresh packet.
                        pkt_overrun_d = !owner_last_s;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pkt_overrun = pkt_overrun_q;

    // State, ownership and packet counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            cnt_q         <= 8'd0;
            pkt_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            pkt_overrun_q <= pkt_overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Two instances share every input: dut_a
// uses the default 64-byte limit, dut_b a 4-byte limit for the forced-release
// cases. Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_ready;

    logic [3:0]  a_req_ready, b_req_ready;
    logic        a_tx_valid, b_tx_valid;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_grant_valid, b_grant_valid;
    logic [1:0]  a_grant_id, b_grant_id;
    logic        a_pkt_overrun, b_pkt_overrun;

    int tests_run;
    int tests_failed;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_PKT(64)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(a_req_ready), .tx_valid(a_tx_valid),
        .tx_data(a_tx_data), .tx_ready(tx_ready), .grant_valid(a_grant_valid),
        .grant_id(a_grant_id), .pkt_overrun(a_pkt_overrun)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_PKT(4)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(b_req_ready), .tx_valid(b_tx_valid),
        .tx_data(b_tx_data), .tx_ready(tx_ready), .grant_valid(b_grant_valid),
        .grant_id(b_grant_id), .pkt_overrun(b_pkt_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic expect_idle(input string tag, input bit use_b);
        check_eq({tag, ".grant_valid"}, use_b ? b_grant_valid : a_grant_valid, 32'd0);
        check_eq({tag, ".tx_valid"},    use_b ? b_tx_valid    : a_tx_valid,    32'd0);
        check_eq({tag, ".req_ready"},   use_b ? b_req_ready   : a_req_ready,   32'd0);
        check_eq({tag, ".grant_id"},    use_b ? b_grant_id    : a_grant_id,    32'd0);
    endtask

    task automatic expect_busy(input string tag, input bit use_b, input logic [1:0] id,
                               input logic [7:0] data, input logic [3:0] rdy);
        check_eq({tag, ".grant_valid"}, use_b ? b_grant_valid : a_grant_valid, 32'd1);
        check_eq({tag, ".grant_id"},    use_b ? b_grant_id    : a_grant_id,    {30'd0, id});
        check_eq({tag, ".tx_valid"},    use_b ? b_tx_valid    : a_tx_valid,    32'd1);
        check_eq({tag, ".tx_data"},     use_b ? b_tx_data     : a_tx_data,     {24'd0, data});
        check_eq({tag, ".req_ready"},   use_b ? b_req_ready   : a_req_ready,   {28'd0, rdy});
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'd0;
        tx_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // ---- 1: reset state, then a 3-byte packet from req0 ----
        do_reset();
        sample();
        expect_idle("t1_reset", 1'b0);
        check_eq("t1_reset.overrun", a_pkt_overrun, 32'd0);
        tick();
        req_valid = 4'b0001;
        set_lane(0, 8'h41);
        sample();
        expect_idle("t1_arb_latency", 1'b0);
        tick();
        sample();
        expect_busy("t1_b0", 1'b0, 2'd0, 8'h41, 4'b0001);
        tick();
        set_lane(0, 8'h42);
        sample();
        expect_busy("t1_b1", 1'b0, 2'd0, 8'h42, 4'b0001);
        tick();
        set_lane(0, 8'h43);
        req_last = 4'b0001;
        sample();
        expect_busy("t1_b2", 1'b0, 2'd0, 8'h43, 4'b0001);
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        sample();
        expect_idle("t1_after", 1'b0);

        // ---- 2: all four request 1-byte packets, order 0,1,2,3,0 ----
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'hD3D2D1D0;
        for (int n = 0; n < 5; n++) begin
            logic [1:0] g;
            g = 2'(n % 4);
            sample();
            expect_idle($sformatf("t2_gap%0d", n), 1'b0);
            tick();
            sample();
            expect_busy($sformatf("t2_grant%0d", n), 1'b0, g, 8'hD0 + 8'(g), 4'b0001 << g);
            tick();
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        sample();
        expect_idle("t2_after", 1'b0);

        // ---- 3: req1 waits while req2 finishes a 5-byte packet ----
        do_reset();
        req_valid = 4'b0100;
        set_lane(2, 8'h20);
        sample();
        expect_idle("t3_arb", 1'b0);
        tick();
        for (int b = 0; b < 5; b++) begin
            set_lane(2, 8'h20 + 8'(b));
            req_last[2] = (b == 4);
            if (b == 1) begin
                req_valid[1] = 1'b1;
                req_last[1]  = 1'b1;
                set_lane(1, 8'h11);
            end
            sample();
            expect_busy($sformatf("t3_req2_b%0d", b), 1'b0, 2'd2, 8'h20 + 8'(b), 4'b0100);
            tick();
        end
        req_valid[2] = 1'b0;
        req_last[2]  = 1'b0;
        sample();
        expect_idle("t3_gap", 1'b0);
        tick();
        sample();
        expect_busy("t3_req1", 1'b0, 2'd1, 8'h11, 4'b0010);
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0000;

        // ---- 4: dut_b (limit 4), req3 sends 6 bytes with last only on byte 6 ----
        do_reset();
        req_valid = 4'b1000;
        set_lane(3, 8'h30);
        sample();
        expect_idle("t4_arb", 1'b1);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_lane(3, 8'h30 + 8'(b));
            sample();
            expect_busy($sformatf("t4_b%0d", b), 1'b1, 2'd3, 8'h30 + 8'(b), 4'b1000);
            check_eq($sformatf("t4_b%0d.overrun", b), b_pkt_overrun, 32'd0);
            tick();
        end
        set_lane(3, 8'h34);
        sample();
        expect_idle("t4_cut", 1'b1);
        check_eq("t4_cut.overrun", b_pkt_overrun, 32'd1);
        tick();
        sample();
        expect_busy("t4_b4", 1'b1, 2'd3, 8'h34, 4'b1000);
        check_eq("t4_b4.overrun", b_pkt_overrun, 32'd0);
        tick();
        set_lane(3, 8'h35);
        req_last = 4'b1000;
        sample();
        expect_busy("t4_b5", 1'b1, 2'd3, 8'h35, 4'b1000);
        tick();
        req_last  = 4'b0000;
        set_lane(3, 8'h40);
        sample();
        expect_idle("t4_end", 1'b1);
        check_eq("t4_end.overrun", b_pkt_overrun, 32'd0);

        // ---- 4b: last on exactly the 4th byte is a normal release ----
        tick();
        for (int b = 0; b < 4; b++) begin
            set_lane(3, 8'h40 + 8'(b));
            req_last[3] = (b == 3);
            sample();
            expect_busy($sformatf("t4b_b%0d", b), 1'b1, 2'd3, 8'h40 + 8'(b), 4'b1000);
            tick();
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        sample();
        expect_idle("t4b_end", 1'b1);
        check_eq("t4b_end.overrun", b_pkt_overrun, 32'd0);

        // ---- 5: tx_ready 1,0,0,1 during a 3-byte req1 packet ----
        do_reset();
        req_valid = 4'b0010;
        set_lane(1, 8'h51);
        sample();
        expect_idle("t5_arb", 1'b0);
        tick();
        sample();
        expect_busy("t5_r1", 1'b0, 2'd1, 8'h51, 4'b0010);
        tick();
        set_lane(1, 8'h52);
        tx_ready = 1'b0;
        sample();
        expect_busy("t5_r0a", 1'b0, 2'd1, 8'h52, 4'b0000);
        tick();
        sample();
        expect_busy("t5_r0b", 1'b0, 2'd1, 8'h52, 4'b0000);
        tick();
        tx_ready = 1'b1;
        sample();
        expect_busy("t5_r1b", 1'b0, 2'd1, 8'h52, 4'b0010);
        tick();
        set_lane(1, 8'h53);
        req_last = 4'b0010;
        sample();
        expect_busy("t5_last", 1'b0, 2'd1, 8'h53, 4'b0010);
        // With a 4-byte limit, stalls must not count towards it.
        expect_busy("t5_last_lim", 1'b1, 2'd1, 8'h53, 4'b0010);
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        sample();
        expect_idle("t5_end", 1'b0);
        check_eq("t5_end.overrun_lim", b_pkt_overrun, 32'd0);

        // ---- 6: reset during byte 2 of a 4-byte req0 packet ----
        do_reset();
        req_valid = 4'b0001;
        set_lane(0, 8'h60);
        tick();
        sample();
        expect_busy("t6_b0", 1'b0, 2'd0, 8'h60, 4'b0001);
        tick();
        set_lane(0, 8'h61);
        sample();
        expect_busy("t6_b1", 1'b0, 2'd0, 8'h61, 4'b0001);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        set_lane(0, 8'h70);
        set_lane(1, 8'h71);
        sample();
        expect_idle("t6_reset", 1'b0);
        check_eq("t6_reset.overrun", a_pkt_overrun, 32'd0);
        tick();
        sample();
        expect_busy("t6_g0", 1'b0, 2'd0, 8'h70, 4'b0001);
        tick();
        sample();
        expect_idle("t6_gap", 1'b0);
        tick();
        sample();
        expect_busy("t6_g1", 1'b0, 2'd1, 8'h71, 4'b0010);
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
